// File: rtl/instr_encoder_loader.sv
// Encodes decoded RV32 instruction fields into 32-bit words and streams them into imem.
// Optional immediate range checking is enabled with `define ENCODER_IMM_CHECK_EN.
`timescale 1ns/1ps
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_wptr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_done;
    logic                r_err;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_imm_ok;
    logic                w_ok;
    logic                w_xfer;
    logic                w_fills;

    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b1;
        case (in_class)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
            3'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
            3'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
            3'd4: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
            default: w_legal = 1'b0;
        endcase
    end

`ifdef ENCODER_IMM_CHECK_EN
    // Upper bits must all equal the sign bit for the value to fit the field.
    always_comb begin
        w_imm_ok = 1'b1;
        case (in_class)
            3'd1, 3'd2, 3'd3: w_imm_ok = (in_imm[31:11] == {21{in_imm[31]}});
            3'd4:             w_imm_ok = (in_imm[31:12] == {20{in_imm[31]}}) && !in_imm[0];
            3'd5:             w_imm_ok = (in_imm[31:20] == {12{in_imm[31]}}) && !in_imm[0];
            default:          w_imm_ok = 1'b1;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^in_imm[31:21];
    assign w_imm_ok = 1'b1;
`endif

    assign w_ok     = w_legal & w_imm_ok;
    assign in_ready = (r_state == S_LOAD) && (r_count < DEPTH_C);
    assign w_xfer   = in_valid & in_ready;
    assign w_fills  = w_ok && ((r_count + (ADDR_W+1)'(1)) == DEPTH_C);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wptr  <= '0;
            r_wdata <= 32'h0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_LOAD;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_wptr  <= BASE_C;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        if (w_ok) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_wptr;
                            r_wdata <= w_word;
                            r_wptr  <= r_wptr + ADDR_W'(1);
                            r_count <= r_count + (ADDR_W+1)'(1);
                        end else begin
                            r_err <= 1'b1;
                        end
                        if (in_last || w_fills) begin
                            r_state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader (DEPTH=4 instance) with hand-computed words.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [10:0] count;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    logic [31:0] ea[$];
    logic [31:0] ed[$];

    instr_encoder_loader #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .arst_n(arst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(32'(imem_addr));
            wd.push_back(imem_wdata);
        end
        if (done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            chk("ready_wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 20 && !done; i++) @(negedge clk);
        if (!done) chk("done_wait", 32'(done), 32'd1);
    endtask

    task automatic clear_q();
        wa.delete(); wd.delete(); ea.delete(); ed.delete();
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'(ea.size()));
        for (int i = 0; i < ea.size(); i++) begin
            if (i < wa.size()) begin
                chk($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
                chk($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int k;
        int nd0;
        bit seen4;
        arst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_class = 3'd0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        chk("idle_ready", 32'(in_ready), 32'd0);

        // single R-type, latency and done timing
        do_start();
        chk("load_ready", 32'(in_ready), 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        chk("r_we",    32'(imem_we), 32'd1);
        chk("r_addr",  32'(imem_addr), 32'd0);
        chk("r_wdata", imem_wdata, 32'h002081B3);
        chk("r_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("r_done",  32'(done), 32'd1);
        chk("r_count", 32'(count), 32'd1);
        @(negedge clk);
        chk("r_done_once", 32'(done), 32'd0);

        // back-to-back I / LOAD / STORE
        clear_q();
        do_start();
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        send(3'd2, 5'd2, 5'd0, 5'd0, 3'd2, 7'd0, 32'd8, 1'b0);
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd4, 1'b1);
        wait_done();
        chk("b2b_count", 32'(count), 32'd3);
        @(negedge clk); #1;
        ea = '{32'd0, 32'd1, 32'd2};
        ed = '{32'h00500093, 32'h00802103, 32'h0020A223};
        cmp_writes("b2b");

        // BEQ negative offset then JAL with last
        clear_q();
        do_start();
        nd0 = n_done;
        send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b0);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1);
        chk("jal_we", 32'(imem_we), 32'd1);
        chk("jal_done_early", 32'(done), 32'd0);
        @(negedge clk);
        chk("jal_done", 32'(done), 32'd1);
        @(negedge clk); #1;
        chk("jal_done_once", 32'(done), 32'd0);
        chk("jal_ndone", 32'(n_done - nd0), 32'd1);
        ea = '{32'd0, 32'd1};
        ed = '{32'hFE208CE3, 32'h010000EF};
        cmp_writes("bj");

        // DEPTH limit: 6 bundles offered without last
        clear_q();
        do_start();
        nd0 = n_done;
        k = 0;
        seen4 = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (k == 4 && !seen4) begin
                chk("full_ready", 32'(in_ready), 32'd0);
                seen4 = 1'b1;
            end
            in_valid = (k < 6);
            in_class = 3'd1; in_rd = 5'(k + 1); in_rs1 = 5'd0;
            in_funct3 = 3'd0; in_imm = 32'(k);
            if (in_valid && in_ready) k++;
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("full_xfers", 32'(k), 32'd4);
        chk("full_ndone", 32'(n_done - nd0), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        ea = '{32'd0, 32'd1, 32'd2, 32'd3};
        ed = '{32'h00000093, 32'h00100113, 32'h00200193, 32'h00300213};
        cmp_writes("full");

        // illegal class between two good bundles
        clear_q();
        do_start();
        chk("ill_err_start", 32'(err), 32'd0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd7, 5'd4, 5'd4, 5'd4, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_nowe", 32'(imem_we), 32'd0);
        chk("ill_count", 32'(count), 32'd1);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        wait_done();
        chk("ill_err_done", 32'(err), 32'd1);
        chk("ill_count_done", 32'(count), 32'd2);
        @(negedge clk); #1;
        ea = '{32'd0, 32'd1};
        ed = '{32'h002081B3, 32'h00500093};
        cmp_writes("ill");
        do_start();
        chk("ill_err_clr", 32'(err), 32'd0);

        // reset one cycle after a transfer
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        chk("pre_rst_addr", 32'(imem_addr), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mrst_we",    32'(imem_we), 32'd0);
        chk("mrst_addr",  32'(imem_addr), 32'd0);
        chk("mrst_wdata", imem_wdata, 32'd0);
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        arst_n = 1'b1;
        do_start();
        clear_q();
        chk("new_count", 32'(count), 32'd0);
        send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
        chk("new_we",    32'(imem_we), 32'd1);
        chk("new_addr",  32'(imem_addr), 32'd0);
        chk("new_wdata", imem_wdata, 32'h00500093);
        @(negedge clk);
        chk("new_done",  32'(done), 32'd1);
        chk("new_count1", 32'(count), 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
